// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between an upstream EX stage, the stage buffer and the downstream MEM stage.
interface pipe_stage_buf_if #(
  parameter int unsigned REG_SZ = 32,
  parameter int unsigned CNT_W  = 2
);
  logic              flush;
  logic              buf_we;
  logic              buf_ack;
  logic [REG_SZ-1:0] ans_in;
  logic [REG_SZ-1:0] dout_in;
  logic [1:0]        rw_e_in;
  logic [1:0]        rw_len_in;
  logic              wb_e_in;
  logic [4:0]        wb_idx_in;
  logic              buf_avail;
  logic              buf_re;
  logic [REG_SZ-1:0] ans_out;
  logic [REG_SZ-1:0] dout_out;
  logic [1:0]        rw_e_out;
  logic [1:0]        rw_len_out;
  logic              wb_e_out;
  logic [4:0]        wb_idx_out;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              unf;

  // Stage side driving writes/reads/flush.
  modport master (
    output flush, buf_we, ans_in, dout_in, rw_e_in, rw_len_in, wb_e_in, wb_idx_in, buf_re,
    input  buf_ack, buf_avail, ans_out, dout_out, rw_e_out, rw_len_out, wb_e_out, wb_idx_out,
           count, ovf, unf
  );

  // Buffer (responder) side.
  modport slave (
    input  flush, buf_we, ans_in, dout_in, rw_e_in, rw_len_in, wb_e_in, wb_idx_in, buf_re,
    output buf_ack, buf_avail, ans_out, dout_out, rw_e_out, rw_len_out, wb_e_out, wb_idx_out,
           count, ovf, unf
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: small FIFO between EX and MEM with ack/avail handshake and flush.
module pipe_stage_buf #(
  parameter int unsigned REG_SZ = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 2
) (
  input  logic           clk,
  input  logic           rst,
  pipe_stage_buf_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [REG_SZ-1:0] ans;
    logic [REG_SZ-1:0] dout;
    logic [1:0]        rw_e;
    logic [1:0]        rw_len;
    logic              wb_e;
    logic [4:0]        wb_idx;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             rearm;
  logic             ack_q;
  logic             ovf_q;
  logic             unf_q;

  logic             avail_c;
  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             ovf_set_c;
  logic             unf_set_c;
  entry_t           wr_entry_c;

  // Handshake decode; flush suppresses push, pop and both sticky flags.
  always_comb begin
    avail_c    = 1'b0;
    full_c     = 1'b0;
    pop_c      = 1'b0;
    push_c     = 1'b0;
    ovf_set_c  = 1'b0;
    unf_set_c  = 1'b0;
    wr_entry_c = '0;

    avail_c = (count_q != '0) && !rearm;
    full_c  = (count_q == CNT_W'(DEPTH));

    wr_entry_c.ans    = bus.ans_in;
    wr_entry_c.dout   = bus.dout_in;
    wr_entry_c.rw_e   = bus.rw_e_in;
    wr_entry_c.rw_len = bus.rw_len_in;
    wr_entry_c.wb_e   = bus.wb_e_in;
    wr_entry_c.wb_idx = bus.wb_idx_in;

    if (!bus.flush) begin
      pop_c     = bus.buf_re && avail_c;
      push_c    = bus.buf_we && (!full_c || pop_c);
      ovf_set_c = bus.buf_we && full_c && !pop_c;
      unf_set_c = bus.buf_re && !avail_c;
    end
  end

  // Entry storage; cleared on reset so the head payload reads zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push_c) begin
      mem[wr_ptr] <= wr_entry_c;
    end
  end

  // Pointers, occupancy, ack pulse, post-pop rearm gap and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rearm   <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rearm   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      rearm <= pop_c;
      ack_q <= push_c;
      if (ovf_set_c) ovf_q <= 1'b1;
      if (unf_set_c) unf_q <= 1'b1;
    end
  end

  // Head entry is read straight from storage; status comes from registers.
  assign bus.ans_out    = mem[rd_ptr].ans;
  assign bus.dout_out   = mem[rd_ptr].dout;
  assign bus.rw_e_out   = mem[rd_ptr].rw_e;
  assign bus.rw_len_out = mem[rd_ptr].rw_len;
  assign bus.wb_e_out   = mem[rd_ptr].wb_e;
  assign bus.wb_idx_out = mem[rd_ptr].wb_idx;
  assign bus.buf_avail  = avail_c;
  assign bus.buf_ack    = ack_q;
  assign bus.count      = count_q;
  assign bus.ovf        = ovf_q;
  assign bus.unf        = unf_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_stage_buf;

  localparam int unsigned REG_SZ = 32;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;

  typedef struct packed {
    logic [31:0] ans;
    logic [31:0] dout;
    logic [1:0]  rw_e;
    logic [1:0]  rw_len;
    logic        wb_e;
    logic [4:0]  wb_idx;
  } ent_t;

  logic clk = 1'b0;
  logic rst;

  pipe_stage_buf_if #(.REG_SZ(REG_SZ), .CNT_W(CNT_W)) bif ();

  pipe_stage_buf #(.REG_SZ(REG_SZ), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents, one-cycle gap after each pop, ack pulse, sticky flags.
  ent_t q[$];
  bit   m_gap, m_ack, m_ovf, m_unf;
  int   checks   = 0;
  int   failures = 0;

  function automatic bit m_avail();
    return (q.size() != 0) && !m_gap;
  endfunction

  task automatic set_payload(input ent_t e);
    bif.ans_in    = e.ans;
    bif.dout_in   = e.dout;
    bif.rw_e_in   = e.rw_e;
    bif.rw_len_in = e.rw_len;
    bif.wb_e_in   = e.wb_e;
    bif.wb_idx_in = e.wb_idx;
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.ans    = $urandom;
    e.dout   = $urandom;
    e.rw_e   = 2'($urandom_range(0, 3));
    e.rw_len = 2'($urandom_range(0, 3));
    e.wb_e   = 1'($urandom_range(0, 1));
    e.wb_idx = 5'($urandom_range(0, 31));
    return e;
  endfunction

  function automatic ent_t mk(input logic [31:0] a, input logic [4:0] idx);
    ent_t e;
    e = rand_ent();
    e.ans    = a;
    e.wb_idx = idx;
    return e;
  endfunction

  // Advance one clock: apply the model rules to the inputs present at the edge, then release strobes.
  task automatic step();
    bit   we, re, fl, r, av, pop, push;
    ent_t e;
    we = bif.buf_we; re = bif.buf_re; fl = bif.flush; r = rst;
    e.ans = bif.ans_in; e.dout = bif.dout_in; e.rw_e = bif.rw_e_in;
    e.rw_len = bif.rw_len_in; e.wb_e = bif.wb_e_in; e.wb_idx = bif.wb_idx_in;
    av = m_avail();
    if (!r) begin
      q.delete(); m_gap = 0; m_ack = 0; m_ovf = 0; m_unf = 0;
    end else if (fl) begin
      q.delete(); m_gap = 0; m_ack = 0;
    end else begin
      pop  = re && av;
      push = we && ((q.size() < int'(DEPTH)) || pop);
      if (we && !push) m_ovf = 1;
      if (re && !av)   m_unf = 1;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
      m_ack = push;
      m_gap = pop;
    end
    @(posedge clk);
    #1;
    bif.buf_we = 1'b0;
    bif.buf_re = 1'b0;
    bif.flush  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bif.buf_we = 1'b1;
      bif.buf_re = 1'b1;
      set_payload(rand_ent());
      step();
    end
    rst = 1'b1;
    checks++;
    if (bif.count !== '0 || bif.buf_avail !== 1'b0 || bif.buf_ack !== 1'b0 ||
        bif.ovf !== 1'b0 || bif.unf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: count=%0d avail=%b ack=%b ovf=%b unf=%b, required 0 0 0 0 0",
               bif.count, bif.buf_avail, bif.buf_ack, bif.ovf, bif.unf);
    end
    checks++;
    if (bif.ans_out !== 32'h0 || bif.wb_idx_out !== 5'h0 || bif.dout_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_payload: ans=%h dout=%h wb_idx=%0d, required zero",
               bif.ans_out, bif.dout_out, bif.wb_idx_out);
    end
  endtask

  task automatic test_single();
    bif.buf_we = 1'b1;
    set_payload(mk(32'h1234, 5'd5));
    step();
    checks++;
    if (bif.buf_ack !== 1'b1 || bif.buf_avail !== 1'b1 || bif.ans_out !== 32'h1234 ||
        bif.wb_idx_out !== 5'd5 || bif.count !== 2'd1) begin
      failures++;
      $display("FAIL single_write: ack=%b avail=%b ans=%h idx=%0d count=%0d, required 1 1 1234 5 1",
               bif.buf_ack, bif.buf_avail, bif.ans_out, bif.wb_idx_out, bif.count);
    end
    step();
    checks++;
    if (bif.buf_ack !== 1'b0) begin
      failures++;
      $display("FAIL single_ack_width: ack=%b, required 0", bif.buf_ack);
    end
    bif.buf_re = 1'b1;
    step();
    checks++;
    if (bif.buf_avail !== 1'b0 || bif.count !== 2'd0 || bif.unf !== 1'b0) begin
      failures++;
      $display("FAIL single_pop: avail=%b count=%0d unf=%b, required 0 0 0",
               bif.buf_avail, bif.count, bif.unf);
    end
  endtask

  task automatic test_fill_ovf();
    for (int v = 1; v <= 3; v++) begin
      bif.buf_we = 1'b1;
      set_payload(mk(32'(v), 5'(v)));
      step();
    end
    checks++;
    if (bif.buf_ack !== 1'b0 || bif.ovf !== 1'b1 || bif.count !== 2'd2 || bif.ans_out !== 32'd1) begin
      failures++;
      $display("FAIL fill_overflow: ack=%b ovf=%b count=%0d head=%0d, required 0 1 2 1",
               bif.buf_ack, bif.ovf, bif.count, bif.ans_out);
    end
    bif.buf_re = 1'b1;
    step();
    checks++;
    if (bif.buf_avail !== 1'b0 || bif.count !== 2'd1) begin
      failures++;
      $display("FAIL pop_gap: avail=%b count=%0d, required 0 1", bif.buf_avail, bif.count);
    end
    step();
    checks++;
    if (bif.buf_avail !== 1'b1 || bif.ans_out !== 32'd2) begin
      failures++;
      $display("FAIL pop_next_head: avail=%b head=%0d, required 1 2", bif.buf_avail, bif.ans_out);
    end
    bif.buf_re = 1'b1;
    step();
    step();
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int v = 1; v <= 2; v++) begin
      bif.buf_we = 1'b1;
      set_payload(mk(32'(v), 5'(v)));
      step();
    end
    bif.buf_we = 1'b1;
    bif.buf_re = 1'b1;
    set_payload(mk(32'd3, 5'd3));
    step();
    checks++;
    if (bif.buf_ack !== 1'b1 || bif.count !== 2'd2 || bif.ovf !== 1'b0 || bif.buf_avail !== 1'b0) begin
      failures++;
      $display("FAIL full_push_pop: ack=%b count=%0d ovf=%b avail=%b, required 1 2 0 0",
               bif.buf_ack, bif.count, bif.ovf, bif.buf_avail);
    end
    for (int v = 2; v <= 3; v++) begin
      step();
      checks++;
      if (bif.buf_avail !== 1'b1 || bif.ans_out !== 32'(v)) begin
        failures++;
        $display("FAIL full_drain_order: avail=%b head=%0d, required 1 %0d", bif.buf_avail, bif.ans_out, v);
      end
      bif.buf_re = 1'b1;
      step();
    end
    checks++;
    if (bif.count !== 2'd0 || bif.unf !== 1'b0) begin
      failures++;
      $display("FAIL full_drain_end: count=%0d unf=%b, required 0 0", bif.count, bif.unf);
    end
  endtask

  task automatic test_flush();
    bit ovf_before;
    for (int v = 1; v <= 2; v++) begin
      bif.buf_we = 1'b1;
      set_payload(mk(32'(v + 20), 5'(v)));
      step();
    end
    ovf_before = bif.ovf;
    bif.flush  = 1'b1;
    bif.buf_we = 1'b1;
    set_payload(mk(32'd99, 5'd9));
    step();
    checks++;
    if (bif.count !== 2'd0 || bif.buf_avail !== 1'b0 || bif.buf_ack !== 1'b0 || bif.ovf !== ovf_before) begin
      failures++;
      $display("FAIL flush: count=%0d avail=%b ack=%b ovf=%b, required 0 0 0 %b",
               bif.count, bif.buf_avail, bif.buf_ack, bif.ovf, ovf_before);
    end
    bif.buf_re = 1'b1;
    step();
    checks++;
    if (bif.unf !== 1'b1 || bif.count !== 2'd0) begin
      failures++;
      $display("FAIL read_empty: unf=%b count=%0d, required 1 0", bif.unf, bif.count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int v = 10; v <= 16; v++) begin
      bif.buf_we = 1'b1;
      set_payload(mk(32'(v), 5'(v)));
      step();
      checks++;
      if (bif.buf_ack !== 1'b1 || bif.buf_avail !== 1'b1 || bif.ans_out !== 32'(v) ||
          bif.wb_idx_out !== 5'(v)) begin
        failures++;
        $display("FAIL wrap_head: ack=%b avail=%b head=%0d idx=%0d, required 1 1 %0d %0d",
                 bif.buf_ack, bif.buf_avail, bif.ans_out, bif.wb_idx_out, v, v);
      end
      bif.buf_re = 1'b1;
      step();
    end
    checks++;
    if (bif.count !== 2'd0 || bif.ovf !== 1'b0 || bif.unf !== 1'b0) begin
      failures++;
      $display("FAIL wrap_end: count=%0d ovf=%b unf=%b, required 0 0 0", bif.count, bif.ovf, bif.unf);
    end
  endtask

  task automatic test_random();
    ent_t h;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 99) != 0);
      bif.flush  = ($urandom_range(0, 29) == 0);
      bif.buf_we = 1'($urandom_range(0, 1));
      bif.buf_re = 1'($urandom_range(0, 1));
      set_payload(rand_ent());
      step();
      rst = 1'b1;
      checks++;
      if (bif.count !== CNT_W'(q.size()) || bif.buf_avail !== m_avail() || bif.buf_ack !== m_ack ||
          bif.ovf !== m_ovf || bif.unf !== m_unf) begin
        failures++;
        $display("FAIL rand_status cyc=%0d: count=%0d avail=%b ack=%b ovf=%b unf=%b, required %0d %b %b %b %b",
                 n, bif.count, bif.buf_avail, bif.buf_ack, bif.ovf, bif.unf,
                 q.size(), m_avail(), m_ack, m_ovf, m_unf);
      end
      if (m_avail()) begin
        h = q[0];
        checks++;
        if (bif.ans_out !== h.ans || bif.dout_out !== h.dout || bif.rw_e_out !== h.rw_e ||
            bif.rw_len_out !== h.rw_len || bif.wb_e_out !== h.wb_e || bif.wb_idx_out !== h.wb_idx) begin
          failures++;
          $display("FAIL rand_head cyc=%0d: ans=%h dout=%h idx=%0d, required %h %h %0d",
                   n, bif.ans_out, bif.dout_out, bif.wb_idx_out, h.ans, h.dout, h.wb_idx);
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    bif.flush  = 1'b0;
    bif.buf_we = 1'b0;
    bif.buf_re = 1'b0;
    set_payload('0);
    #2;
    test_reset();
    test_single();
    test_fill_ovf();
    test_full_simul();
    test_flush();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
